// File: rtl/bsg_manycore_lock_mem_bridge.sv
// Downstream stage of the lock controller: arbitrates the combined request
// stream against the core for the tile's single-port data SRAM and returns
// exactly one response per accepted request, one cycle after acceptance.
// Optional statistics counters: define BSG_MANYCORE_LOCK_MEM_BRIDGE_STATS_EN.
module bsg_manycore_lock_mem_bridge #(
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 32,
    parameter int unsigned x_cord_width_p = 4,
    parameter int unsigned y_cord_width_p = 4,
    parameter int unsigned mem_els_p      = 1024,
    parameter int unsigned max_stall_p    = 16,
    parameter logic [data_width_p-1:0] err_data_p = '0,
    localparam int unsigned mask_width_lp     = data_width_p >> 3,
    localparam int unsigned mem_addr_width_lp = $clog2(mem_els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         in_v_i,
    output logic                         in_yumi_o,
    input  logic [data_width_p-1:0]      in_data_i,
    input  logic [mask_width_lp-1:0]     in_mask_i,
    input  logic [addr_width_p-1:0]      in_addr_i,
    input  logic                         in_we_i,
    input  logic [x_cord_width_p-1:0]    in_x_cord_i,
    input  logic [y_cord_width_p-1:0]    in_y_cord_i,
    input  logic                         core_v_i,
    output logic                         core_stall_o,
    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [mem_addr_width_lp-1:0] mem_addr_o,
    output logic [data_width_p-1:0]      mem_data_o,
    output logic [mask_width_lp-1:0]     mem_mask_o,
    input  logic [data_width_p-1:0]      mem_data_i,
    output logic                         returning_v_o,
    output logic [data_width_p-1:0]      returning_data_o,
    output logic                         err_o
`ifdef BSG_MANYCORE_LOCK_MEM_BRIDGE_STATS_EN
    ,
    output logic [31:0]                  load_cnt_o,
    output logic [31:0]                  store_cnt_o,
    output logic [31:0]                  err_cnt_o,
    output logic [31:0]                  force_cnt_o
`endif
);

    localparam int unsigned stall_width_lp = $clog2(max_stall_p + 1);
    localparam logic [stall_width_lp-1:0] max_stall_lp = stall_width_lp'(max_stall_p);
    // One extra bit so a depth equal to 2**addr_width_p still compares correctly
    localparam logic [addr_width_p:0] mem_els_lp = (addr_width_p + 1)'(mem_els_p);

    logic [stall_width_lp-1:0] stall_cnt_q;
    logic                      force_grant;
    logic                      grant;
    logic                      in_range;
    logic                      resp_v_q;
    logic                      resp_load_q;
    logic                      resp_err_q;

    // Source coordinates only matter to an external error reporter
    logic unused_cord;
    assign unused_cord = ^{in_x_cord_i, in_y_cord_i};

    // Grant decision: core wins unless it has starved the bridge for max_stall_p cycles
    always_comb begin
        in_range     = ({1'b0, in_addr_i} < mem_els_lp);
        force_grant  = (stall_cnt_q == max_stall_lp);
        grant        = ~reset_i & in_v_i & (~core_v_i | force_grant);
        in_yumi_o    = grant;
        mem_v_o      = grant & in_range;
        mem_w_o      = mem_v_o & in_we_i;
        core_stall_o = grant & core_v_i;
        mem_addr_o   = in_addr_i[mem_addr_width_lp-1:0];
        mem_data_o   = in_data_i;
        mem_mask_o   = in_mask_i;
    end

    // Starvation counter: counts consecutive cycles the core blocks a pending request
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (grant || !in_v_i) begin
            stall_cnt_q <= '0;
        end else if (core_v_i && (stall_cnt_q != max_stall_lp)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Response stage: one entry per grant, shown the cycle after acceptance
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_v_q    <= 1'b0;
            resp_load_q <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            resp_v_q    <= grant;
            resp_load_q <= grant & ~in_we_i;
            resp_err_q  <= grant & ~in_range;
        end
    end

    // SRAM read data arrives in the response cycle, so the data mux is combinational
    always_comb begin
        returning_v_o    = resp_v_q;
        err_o            = resp_v_q & resp_err_q;
        returning_data_o = '0;
        if (resp_v_q) begin
            if (resp_err_q) begin
                returning_data_o = err_data_p;
            end else if (resp_load_q) begin
                returning_data_o = mem_data_i;
            end
        end
    end

`ifdef BSG_MANYCORE_LOCK_MEM_BRIDGE_STATS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [31:0] err_cnt_q;
    logic [31:0] force_cnt_q;

    // Saturating event counters for granted loads, stores, range errors and forced grants
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
            force_cnt_q <= '0;
        end else begin
            if (grant && !in_we_i && (load_cnt_q != '1)) load_cnt_q <= load_cnt_q + 1'b1;
            if (grant && in_we_i && (store_cnt_q != '1)) store_cnt_q <= store_cnt_q + 1'b1;
            if (grant && !in_range && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
            if (grant && core_v_i && (force_cnt_q != '1)) force_cnt_q <= force_cnt_q + 1'b1;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign force_cnt_o = force_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_lock_mem_bridge.sv
// Directed, table-driven bench for bsg_manycore_lock_mem_bridge with a
// behavioural single-port SRAM (1-cycle read latency) on the memory side.
module tb_bsg_manycore_lock_mem_bridge;

    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        in_v;
    logic        in_yumi;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic [31:0] in_addr;
    logic        in_we;
    logic [3:0]  in_x;
    logic [3:0]  in_y;
    logic        core_v;
    logic        core_stall;
    logic        mem_v;
    logic        mem_w;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        ret_v;
    logic [31:0] ret_data;
    logic        err;

    int checks = 0;
    int failures = 0;

    bsg_manycore_lock_mem_bridge #(
        .data_width_p  (32),
        .addr_width_p  (32),
        .x_cord_width_p(4),
        .y_cord_width_p(4),
        .mem_els_p     (1024),
        .max_stall_p   (16),
        .err_data_p    (ErrData)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .in_v_i          (in_v),
        .in_yumi_o       (in_yumi),
        .in_data_i       (in_data),
        .in_mask_i       (in_mask),
        .in_addr_i       (in_addr),
        .in_we_i         (in_we),
        .in_x_cord_i     (in_x),
        .in_y_cord_i     (in_y),
        .core_v_i        (core_v),
        .core_stall_o    (core_stall),
        .mem_v_o         (mem_v),
        .mem_w_o         (mem_w),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_wdata),
        .mem_mask_o      (mem_mask),
        .mem_data_i      (mem_rdata),
        .returning_v_o   (ret_v),
        .returning_data_o(ret_data),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked write, registered read
    logic [31:0] sram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_v && mem_w) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (mem_v && !mem_w) mem_rdata <= sram[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (actual running, required finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge; checks follow #1 later
    task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask, input logic cv);
        @(negedge clk);
        in_v    = v;
        in_we   = we;
        in_addr = addr;
        in_data = data;
        in_mask = mask;
        core_v  = cv;
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        core_v;
        logic        yumi;
        logic        stall;
        logic        mem_v;
        logic        mem_w;
        logic [9:0]  maddr;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [12];
    int   resp_seen;

    initial begin
        // Each row is one cycle; response columns describe the previous row's request
        vecs[0]  = '{1, 1, 5,    32'hA5A5_1234, 4'hF, 0, 1, 0, 1, 1, 5,   0, 32'h0, 0};
        vecs[1]  = '{1, 0, 5,    32'h0,         4'hF, 0, 1, 0, 1, 0, 5,   1, 32'h0, 0};
        vecs[2]  = '{0, 0, 0,    32'h0,         4'h0, 0, 0, 0, 0, 0, 0,   1, 32'hA5A5_1234, 0};
        vecs[3]  = '{1, 1, 7,    32'h1122_3344, 4'h5, 0, 1, 0, 1, 1, 7,   0, 32'h0, 0};
        vecs[4]  = '{1, 0, 7,    32'h0,         4'h0, 0, 1, 0, 1, 0, 7,   1, 32'h0, 0};
        vecs[5]  = '{0, 0, 0,    32'h0,         4'h0, 0, 0, 0, 0, 0, 0,   1, 32'h0022_0044, 0};
        vecs[6]  = '{1, 0, 1024, 32'h0,         4'h0, 0, 1, 0, 0, 0, 0,   0, 32'h0, 0};
        vecs[7]  = '{1, 1, 2000, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 0, 0, 976, 1, ErrData, 1};
        vecs[8]  = '{1, 0, 5,    32'h0,         4'h0, 1, 0, 0, 0, 0, 5,   1, ErrData, 1};
        vecs[9]  = '{1, 0, 5,    32'h0,         4'h0, 0, 1, 0, 1, 0, 5,   0, 32'h0, 0};
        vecs[10] = '{0, 0, 0,    32'h0,         4'h0, 1, 0, 0, 0, 0, 0,   1, 32'hA5A5_1234, 0};
        vecs[11] = '{0, 0, 0,    32'h0,         4'h0, 0, 0, 0, 0, 0, 0,   0, 32'h0, 0};

        reset = 1'b1;
        in_v = 0; in_we = 0; in_addr = 0; in_data = 0; in_mask = 0; core_v = 0;
        in_x = 4'd3; in_y = 4'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_yumi", {31'b0, in_yumi}, 32'd0);
        chk("reset_mem_v", {31'b0, mem_v}, 32'd0);
        chk("reset_ret_v", {31'b0, ret_v}, 32'd0);
        chk("reset_ret_data", ret_data, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].mask,
                  vecs[i].core_v);
            chk($sformatf("v%0d_yumi", i), {31'b0, in_yumi}, {31'b0, vecs[i].yumi});
            chk($sformatf("v%0d_core_stall", i), {31'b0, core_stall}, {31'b0, vecs[i].stall});
            chk($sformatf("v%0d_mem_v", i), {31'b0, mem_v}, {31'b0, vecs[i].mem_v});
            chk($sformatf("v%0d_mem_w", i), {31'b0, mem_w}, {31'b0, vecs[i].mem_w});
            chk($sformatf("v%0d_mem_addr", i), {22'b0, mem_addr}, {22'b0, vecs[i].maddr});
            chk($sformatf("v%0d_ret_v", i), {31'b0, ret_v}, {31'b0, vecs[i].rv});
            chk($sformatf("v%0d_ret_data", i), ret_data, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
        end

        // Back-to-back: 8 stores then 8 loads, one per cycle, responses in order
        resp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'(10 + i), 32'h100 + 32'(i), 4'hF, 0);
            chk($sformatf("b2b_st%0d_yumi", i), {31'b0, in_yumi}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'(10 + i), 32'h0, 4'h0, 0);
            chk($sformatf("b2b_ld%0d_yumi", i), {31'b0, in_yumi}, 32'd1);
            chk($sformatf("b2b_ld%0d_ret_v", i), {31'b0, ret_v}, 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b_ld%0d_data", i - 1), ret_data, 32'h100 + 32'(i - 1));
                resp_seen++;
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("b2b_ld7_ret_v", {31'b0, ret_v}, 32'd1);
        chk("b2b_ld7_data", ret_data, 32'h107);
        if (ret_v) resp_seen++;
        chk("b2b_load_responses", 32'(resp_seen), 32'd8);

        // Starvation: core holds the port, bridge forced through on cycle 17
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 5, 0, 0, 1);
            chk($sformatf("starve_c%0d_yumi", i), {31'b0, in_yumi}, 32'd0);
            chk($sformatf("starve_c%0d_stall", i), {31'b0, core_stall}, 32'd0);
        end
        drive(1, 0, 5, 0, 0, 1);
        chk("force_yumi", {31'b0, in_yumi}, 32'd1);
        chk("force_core_stall", {31'b0, core_stall}, 32'd1);
        chk("force_mem_v", {31'b0, mem_v}, 32'd1);
        drive(1, 0, 6, 0, 0, 1);
        chk("force_ret_v", {31'b0, ret_v}, 32'd1);
        chk("force_ret_data", ret_data, 32'hA5A5_1234);
        chk("after_force_cnt_cleared", {31'b0, in_yumi}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("after_force_no_resp", {31'b0, ret_v}, 32'd0);

        // Reset the cycle after a grant, then a normal load completes
        drive(1, 0, 5, 0, 0, 0);
        chk("pre_reset_grant", {31'b0, in_yumi}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        in_v  = 1'b1;
        in_addr = 32'd7;
        #1;
        chk("in_reset_yumi", {31'b0, in_yumi}, 32'd0);
        chk("in_reset_mem_v", {31'b0, mem_v}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_ret_v", {31'b0, ret_v}, 32'd0);
        chk("post_reset_err", {31'b0, err}, 32'd0);
        chk("post_reset_ret_data", ret_data, 32'd0);
        drive(1, 0, 5, 0, 0, 0);
        chk("post_reset_load_yumi", {31'b0, in_yumi}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset_load_ret_v", {31'b0, ret_v}, 32'd1);
        chk("post_reset_load_data", ret_data, 32'hA5A5_1234);
        chk("post_reset_load_err", {31'b0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
